active_list_buffer: RTL and testbench
=====================================

// Module: active_list_buffer
// PURPOSE
//  Double-buffered (ping-pong) active-sprite list between the sprite scanner and the line drawer.
//  Scanner appends {tilemap,bitmap} address entries for line N+1 into the back bank.
//  Drawer streams line N's entries out of the front bank over a valid/ready interface.
//  Banks exchange on a per-line swap pulse. Generalises the single-bank, unhandshaked
//  active-address BRAM: parametrised depth/widths, counts, overflow and flow control.
// PARAMETERS
//  DEPTH       512  entries per bank (power of 2); memory = 2*DEPTH words
//  TILEMAP_W   36   width of active_tilemap_addr_t
//  BITMAP_W    36   width of active_bitmap_addr_t
//  CNT_W       $clog2(DEPTH+1)  (localparam) count width
// PORTS
//  clk_draw           in   1         draw-domain clock, all logic on posedge
//  rst_draw           in   1         synchronous, active-high reset
//  line_swap          in   1         1-cycle pulse: back bank becomes front, new back emptied
//  push_valid         in   1         append entry to back bank (no backpressure; check push_full)
//  push_tilemap_addr  in   TILEMAP_W entry tilemap address
//  push_bitmap_addr   in   BITMAP_W  entry bitmap address
//  push_full          out  1         back_count == DEPTH
//  back_count         out  CNT_W     entries written to back bank this line
//  overflow           out  1         sticky: a push was dropped since last swap
//  pop_valid          out  1         pop_* data valid
//  pop_ready          in   1         consumer accepts entry when pop_valid&&pop_ready
//  pop_tilemap_addr   out  TILEMAP_W front entry tilemap address
//  pop_bitmap_addr    out  BITMAP_W  front entry bitmap address
//  pop_index          out  CNT_W-1.. index of the presented entry within the front bank
//  front_count        out  CNT_W     entries in front bank (latched at swap)
//  front_done         out  1         all front entries consumed (rd_ptr==front_count && !pop_valid)
// BEHAVIOUR
//  Reset: wr_bank=0, back_count=0, front_count=0, rd_ptr=0, overflow=0, pop_valid=0,
//   front_done=1, push_full=0. Memory contents are not reset; pop data is don't-care while !pop_valid.
//  Write: push_valid && !push_full -> mem[{wr_bank,back_count}] <= {bitmap,tilemap}; back_count++.
//   push_valid && push_full -> entry dropped, overflow <= 1. No other effect.
//  Swap (line_swap=1): wr_bank <= ~wr_bank; front_count <= back_count (+1 if a same-cycle push
//   is accepted: the push lands in the outgoing back bank and is handed over); back_count <= 0;
//   overflow <= 0 (a same-cycle dropped push is lost without flagging); rd_ptr <= 0; pop_valid <= 0.
//   An unconsumed front stream is abandoned. A same-cycle pop handshake is still honoured.
//  Read: rd_en = (rd_ptr < front_count) && (!pop_valid || pop_ready) && !line_swap.
//   rd_en -> BRAM reads mem[{~wr_bank,rd_ptr}], rd_ptr++, pop_valid <= 1 next cycle (latency 1).
//   !rd_en && pop_ready -> pop_valid <= 0. The BRAM output register is only loaded on rd_en,
//   so pop_* stays stable while stalled. Throughput is 1 entry/cycle with pop_ready held high.
//  pop_index = rd_ptr-1 captured alongside the data.
//  Read/write never collide: the banks are disjoint by construction. The read bank equals the
//   written bank only across a swap, and the read is suppressed in the swap cycle.
//  Empty front (front_count=0): pop_valid never rises; front_done=1.
//  Reset mid-line: all state returns to reset values; the stale back entries are unreachable.
// STRUCTURE
//  sprite_types.sv package: active_tilemap_addr_t, active_bitmap_addr_t, active_entry_t
//   (packed {bitmap,tilemap}), and ACTIVE_LIST_DEPTH default constant.
//  Sub-module active_list_bram: simple dual-port, depth 2*DEPTH, width TILEMAP_W+BITMAP_W,
//   write port plus registered read with read-enable (holds output when re=0); infers block RAM.
//  Top level: pointer/count registers, bank select, overflow flag, pop_valid register.
// TESTING
//  1 reset, swap, push 3 entries (A,B,C), swap, pop_ready=1 -> pop A,B,C on 3 consecutive
//    cycles starting 1 cycle after swap+1, pop_index 0,1,2, then front_done=1.
//  2 front holds 4 entries, pop_ready toggles 1,0,0,1,... -> each entry is held stable while
//    stalled; no duplicates or drops; order preserved.
//  3 DEPTH=8: push 10 entries -> push_full=1 after 8, overflow=1, back_count=8;
//    swap -> overflow=0, front_count=8.
//  4 push in the same cycle as line_swap with back_count=2 -> front_count=3; new back_count=0.
//  5 swap while the front stream is half-consumed (2 of 5) -> pop_valid=0 the next cycle;
//    the stream restarts at index 0 of the new front.
//  6 assert rst_draw mid-stream -> next cycle pop_valid=0, front_count=0, back_count=0,
//    front_done=1.

Source files
------------

// File: rtl/active_list_buffer_pkg.sv
// Shared types and defaults for the ping-pong active-sprite list between
// the sprite scanner and the line drawer.
package active_list_buffer_pkg;

  localparam int ACTIVE_LIST_DEPTH = 512;
  localparam int ACTIVE_TILEMAP_W  = 36;
  localparam int ACTIVE_BITMAP_W   = 36;

  typedef logic [ACTIVE_TILEMAP_W-1:0] active_tilemap_addr_t;
  typedef logic [ACTIVE_BITMAP_W-1:0]  active_bitmap_addr_t;

  // Memory word layout: bitmap address in the upper bits, tilemap in the lower.
  typedef struct packed {
    active_bitmap_addr_t  bitmap;
    active_tilemap_addr_t tilemap;
  } active_entry_t;

endpackage

// File: rtl/active_list_buffer_bram.sv
// Simple dual-port RAM holding both banks of the active list. The read
// output register only loads when re is high, so it holds while stalled.
module active_list_buffer_bram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 72
) (
  input  logic              clk_draw,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_draw) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_draw) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/active_list_buffer.sv
// Double-buffered active-sprite list: the scanner fills the back bank for the
// next line while the drawer streams the front bank; line_swap exchanges them.
module active_list_buffer
  import active_list_buffer_pkg::*;
#(
  parameter int DEPTH     = ACTIVE_LIST_DEPTH,
  parameter int TILEMAP_W = ACTIVE_TILEMAP_W,
  parameter int BITMAP_W  = ACTIVE_BITMAP_W,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk_draw,
  input  logic                 rst_draw,
  input  logic                 line_swap,
  input  logic                 push_valid,
  input  logic [TILEMAP_W-1:0] push_tilemap_addr,
  input  logic [BITMAP_W-1:0]  push_bitmap_addr,
  output logic                 push_full,
  output logic [CNT_W-1:0]     back_count,
  output logic                 overflow,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [TILEMAP_W-1:0] pop_tilemap_addr,
  output logic [BITMAP_W-1:0]  pop_bitmap_addr,
  output logic [CNT_W-2:0]     pop_index,
  output logic [CNT_W-1:0]     front_count,
  output logic                 front_done
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int DATA_W = TILEMAP_W + BITMAP_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             wr_bank;
  logic [CNT_W-1:0] rd_ptr;
  logic             push_acc;
  logic             push_drop;
  logic             rd_en;
  logic [DATA_W-1:0] rd_data;

  assign push_full = (back_count == FULL_CNT);
  assign push_acc  = push_valid && !push_full;
  assign push_drop = push_valid && push_full;

  // pop_* is a valid/ready stream: an entry transfers on the cycle both
  // pop_valid and pop_ready are high; while pop_valid && !pop_ready the
  // presented entry and its index hold steady.
  assign rd_en = (rd_ptr < front_count) && (!pop_valid || pop_ready) && !line_swap;

  // Banks are addressed by the top address bit, so writes (wr_bank) and
  // reads (~wr_bank) can only meet across a swap, where the read is suppressed.
  active_list_buffer_bram #(
    .ADDR_W (IDX_W + 1),
    .DATA_W (DATA_W)
  ) u_bram (
    .clk_draw (clk_draw),
    .we       (push_acc),
    .waddr    ({wr_bank, back_count[IDX_W-1:0]}),
    .wdata    ({push_bitmap_addr, push_tilemap_addr}),
    .re       (rd_en),
    .raddr    ({~wr_bank, rd_ptr[IDX_W-1:0]}),
    .rdata    (rd_data)
  );

  assign pop_tilemap_addr = rd_data[TILEMAP_W-1:0];
  assign pop_bitmap_addr  = rd_data[DATA_W-1:TILEMAP_W];
  assign front_done       = (rd_ptr == front_count) && !pop_valid;

  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      wr_bank     <= 1'b0;
      back_count  <= '0;
      front_count <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      pop_valid   <= 1'b0;
      pop_index   <= '0;
    end else if (line_swap) begin
      // A push accepted in the swap cycle lands in the outgoing bank and is handed over.
      wr_bank     <= ~wr_bank;
      front_count <= back_count + (push_acc ? CNT_ONE : '0);
      back_count  <= '0;
      overflow    <= 1'b0;
      rd_ptr      <= '0;
      pop_valid   <= 1'b0;
    end else begin
      if (push_acc)  back_count <= back_count + CNT_ONE;
      if (push_drop) overflow   <= 1'b1;
      if (rd_en) begin
        rd_ptr    <= rd_ptr + CNT_ONE;
        pop_index <= rd_ptr[IDX_W-1:0];
        pop_valid <= 1'b1;
      end else if (pop_ready) begin
        pop_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_active_list_buffer.sv
// Bench for active_list_buffer: directed scenarios plus random traffic, each
// cycle compared against a queue-based model of the ping-pong list.
module tb_active_list_buffer;

  localparam int DEPTH = 8;
  localparam int TW    = 36;
  localparam int BW    = 36;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EW    = TW + BW;

  logic             clk_draw = 1'b0;
  logic             rst_draw;
  logic             line_swap;
  logic             push_valid;
  logic [TW-1:0]    push_tilemap_addr;
  logic [BW-1:0]    push_bitmap_addr;
  logic             push_full;
  logic [CNT_W-1:0] back_count;
  logic             overflow;
  logic             pop_valid;
  logic             pop_ready;
  logic [TW-1:0]    pop_tilemap_addr;
  logic [BW-1:0]    pop_bitmap_addr;
  logic [CNT_W-2:0] pop_index;
  logic [CNT_W-1:0] front_count;
  logic             front_done;

  active_list_buffer #(
    .DEPTH     (DEPTH),
    .TILEMAP_W (TW),
    .BITMAP_W  (BW)
  ) dut (
    .clk_draw          (clk_draw),
    .rst_draw          (rst_draw),
    .line_swap         (line_swap),
    .push_valid        (push_valid),
    .push_tilemap_addr (push_tilemap_addr),
    .push_bitmap_addr  (push_bitmap_addr),
    .push_full         (push_full),
    .back_count        (back_count),
    .overflow          (overflow),
    .pop_valid         (pop_valid),
    .pop_ready         (pop_ready),
    .pop_tilemap_addr  (pop_tilemap_addr),
    .pop_bitmap_addr   (pop_bitmap_addr),
    .pop_index         (pop_index),
    .front_count       (front_count),
    .front_done        (front_done)
  );

  always #5 clk_draw = ~clk_draw;

  // Reference model: back bank contents, the not-yet-consumed front entries
  // (exp_q), front size, entries fetched so far and whether one is on display.
  logic [EW-1:0] back_q[$];
  logic [EW-1:0] exp_q[$];
  int            front_size;
  int            fetched;
  bit            m_pv;
  bit            m_ovf;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    back_q.delete();
    exp_q.delete();
    front_size = 0;
    fetched    = 0;
    m_pv       = 1'b0;
    m_ovf      = 1'b0;
  endtask

  function automatic logic [EW-1:0] mk(input int k);
    logic [EW-1:0] e;
    e = {4'hB, 32'(k * 17 + 3), 4'hA, 32'(k)};
    return e;
  endfunction

  // One clock cycle, entered and left at a negedge: apply inputs, compare
  // the registered outputs against the model, then advance both.
  task automatic step(input bit rst, input bit swap, input bit pv, input bit pr,
                      input logic [EW-1:0] d);
    bit full;
    rst_draw   = rst;
    line_swap  = swap;
    push_valid = pv;
    pop_ready  = pr;
    {push_bitmap_addr, push_tilemap_addr} = d;
    #1;
    chk("pop_valid", EW'(pop_valid), EW'(m_pv));
    if (m_pv) begin
      chk("pop_data", {pop_bitmap_addr, pop_tilemap_addr}, exp_q[0]);
      chk("pop_index", EW'(pop_index), EW'(front_size - exp_q.size()));
    end
    chk("back_count", EW'(back_count), EW'(back_q.size()));
    chk("front_count", EW'(front_count), EW'(front_size));
    chk("overflow", EW'(overflow), EW'(m_ovf));
    chk("push_full", EW'(push_full), EW'(back_q.size() == DEPTH));
    chk("front_done", EW'(front_done), EW'(fetched == front_size && !m_pv));

    if (rst) begin
      model_reset();
    end else begin
      full = (back_q.size() == DEPTH);
      if (m_pv && pr) void'(exp_q.pop_front());
      if (swap) begin
        if (pv && !full) back_q.push_back(d);
        exp_q      = back_q;
        front_size = back_q.size();
        back_q.delete();
        m_ovf   = 1'b0;
        fetched = 0;
        m_pv    = 1'b0;
      end else begin
        if (pv) begin
          if (!full) back_q.push_back(d);
          else m_ovf = 1'b1;
        end
        if (fetched < front_size && (!m_pv || pr)) begin
          m_pv = 1'b1;
          fetched++;
        end else if (pr) begin
          m_pv = 1'b0;
        end
      end
    end
    @(negedge clk_draw);
  endtask

  task automatic idle(input int n, input bit pr);
    for (int i = 0; i < n; i++) step(0, 0, 0, pr, '0);
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, mk(base + i));
  endtask

  initial begin
    logic [95:0] r;
    int          seen_cycle;
    rst_draw = 1'b1; line_swap = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_tilemap_addr = '0; push_bitmap_addr = '0;
    repeat (2) @(posedge clk_draw);
    @(negedge clk_draw);
    model_reset();

    // 1: reset state, then A,B,C streamed back-to-back
    step(1, 0, 0, 0, '0);
    chk("reset_front_done", EW'(front_done), EW'(1));
    step(0, 1, 0, 0, '0);
    push_n(3, 100);
    step(0, 1, 0, 1, '0);
    seen_cycle = -1;
    for (int i = 0; i < 6; i++) begin
      if (pop_valid && seen_cycle < 0) seen_cycle = i;
      step(0, 0, 0, 1, '0);
    end
    chk("first_pop_latency", EW'(seen_cycle), EW'(1));
    chk("stream_done", EW'(front_done), EW'(1));

    // 2: four entries drained with a stalling consumer
    push_n(4, 200);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, (i % 3) == 0, '0);
    chk("stall_done", EW'(front_done), EW'(1));

    // 3: overfill the back bank
    step(0, 1, 0, 0, '0);
    push_n(10, 300);
    chk("ovf_back_count", EW'(back_count), EW'(DEPTH));
    chk("ovf_flag", EW'(overflow), EW'(1));
    chk("ovf_full", EW'(push_full), EW'(1));
    step(0, 1, 0, 0, '0);
    chk("ovf_cleared", EW'(overflow), EW'(0));
    chk("ovf_front_count", EW'(front_count), EW'(DEPTH));
    idle(DEPTH + 3, 1);

    // 4: push landing in the swap cycle is handed over
    push_n(2, 400);
    step(0, 1, 1, 1, mk(402));
    chk("swap_push_front", EW'(front_count), EW'(3));
    chk("swap_push_back", EW'(back_count), EW'(0));
    idle(6, 1);

    // 5: swap abandons a half-consumed stream
    push_n(5, 500);
    step(0, 1, 0, 0, '0);
    push_n(2, 600);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    chk("abandon_pop_valid", EW'(pop_valid), EW'(0));
    idle(5, 1);

    // 6: reset mid-stream
    push_n(4, 700);
    step(0, 1, 0, 0, '0);
    push_n(2, 800);
    step(0, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    chk("rst_pop_valid", EW'(pop_valid), EW'(0));
    chk("rst_front_count", EW'(front_count), EW'(0));
    chk("rst_back_count", EW'(back_count), EW'(0));
    chk("rst_front_done", EW'(front_done), EW'(1));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, r[EW-1:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
